exception_ctrl: RTL

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/exception_ctrl.sv
// Purpose: MEM-stage exception/interrupt arbiter with CP0 bypass, pipeline flush and handler PC select.
// Latency: 1 cycle from MEM inputs to registered outputs; each exception is followed by exactly one FLUSH cycle.
// Backpressure: none; MEM inputs are ignored during FLUSH. Optional timer: EXCEPTION_CTRL_TIMER_INT_EN.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          CP0_ADDR_BUS = 5,
  parameter int          EXC_TYPE_BUS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_pc,
  input  logic                    mem_delayslot,
  input  logic [7:0]              mem_exc_flags,
  input  logic [31:0]             mem_badvaddr,
  input  logic [31:0]             cp0_status_i,
  input  logic [31:0]             cp0_cause_i,
  input  logic [31:0]             cp0_epc_i,
  input  logic [31:0]             cp0_count_i,
  input  logic                    wb_cp0_we,
  input  logic [CP0_ADDR_BUS-1:0] wb_cp0_addr,
  input  logic [31:0]             wb_cp0_data,
  input  logic [5:0]              interrupt_i,
  output logic [5:0]              interrupt_o,
  output logic [EXC_TYPE_BUS-1:0] exception_type,
  output logic                    delayslot_flag,
  output logic [31:0]             current_pc_addr,
  output logic [31:0]             badvaddr_o,
  output logic                    flush_o,
  output logic [31:0]             exc_pc_o
);

  // CP0 register numbers
  localparam logic [CP0_ADDR_BUS-1:0] CP0_REG_COMPARE = CP0_ADDR_BUS'(11);
  localparam logic [CP0_ADDR_BUS-1:0] CP0_REG_STATUS  = CP0_ADDR_BUS'(12);
  localparam logic [CP0_ADDR_BUS-1:0] CP0_REG_CAUSE   = CP0_ADDR_BUS'(13);
  localparam logic [CP0_ADDR_BUS-1:0] CP0_REG_EPC     = CP0_ADDR_BUS'(14);

  // Software-writable fields: status IM[15:8], EXL[1], IE[0]; cause IP[9:8]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Exception type encoding
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_NONE = EXC_TYPE_BUS'(0);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_INT  = EXC_TYPE_BUS'(1);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ADEL = EXC_TYPE_BUS'(2);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ADES = EXC_TYPE_BUS'(3);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_SYS  = EXC_TYPE_BUS'(4);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_BP   = EXC_TYPE_BUS'(5);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_RI   = EXC_TYPE_BUS'(6);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_OV   = EXC_TYPE_BUS'(7);
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ERET = EXC_TYPE_BUS'(8);

  // FSM states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]              state;
  logic [31:0]             status_byp;
  logic [31:0]             cause_byp;
  logic [31:0]             epc_byp;
  logic                    int_req;
  logic                    is_fetch_fault;
  logic [EXC_TYPE_BUS-1:0] exc_sel;
  logic                    unused_bits;

  // Forward the in-flight CP0 write so a just-written status/cause/epc is honoured immediately
  always_comb begin
    status_byp = cp0_status_i;
    cause_byp  = cp0_cause_i;
    epc_byp    = cp0_epc_i;
    if (wb_cp0_we && (wb_cp0_addr == CP0_REG_STATUS)) begin
      status_byp = (cp0_status_i & ~STATUS_WMASK) | (wb_cp0_data & STATUS_WMASK);
    end
    if (wb_cp0_we && (wb_cp0_addr == CP0_REG_CAUSE)) begin
      cause_byp = (cp0_cause_i & ~CAUSE_WMASK) | (wb_cp0_data & CAUSE_WMASK);
    end
    if (wb_cp0_we && (wb_cp0_addr == CP0_REG_EPC)) begin
      epc_byp = wb_cp0_data;
    end
  end

  // Interrupt only attaches to a valid instruction, with IE set, EXL clear and an enabled pending line
  assign int_req = mem_valid & status_byp[0] & ~status_byp[1]
                 & (|(cause_byp[15:8] & status_byp[15:8]));

  // A fetch fault reports the PC as bad address, but only if it actually wins arbitration
  assign is_fetch_fault = mem_exc_flags[7] & ~int_req;

  // Fixed-priority arbitration: INT > IF > RI > OV > BP > SYS > ADEL > ADES > ERET
  always_comb begin
    exc_sel = EXC_TYPE_NONE;
    if (!mem_valid) begin
      exc_sel = EXC_TYPE_NONE;
    end else if (int_req) begin
      exc_sel = EXC_TYPE_INT;
    end else if (mem_exc_flags[7]) begin
      exc_sel = EXC_TYPE_ADEL;
    end else if (mem_exc_flags[6]) begin
      exc_sel = EXC_TYPE_RI;
    end else if (mem_exc_flags[5]) begin
      exc_sel = EXC_TYPE_OV;
    end else if (mem_exc_flags[4]) begin
      exc_sel = EXC_TYPE_BP;
    end else if (mem_exc_flags[3]) begin
      exc_sel = EXC_TYPE_SYS;
    end else if (mem_exc_flags[2]) begin
      exc_sel = EXC_TYPE_ADEL;
    end else if (mem_exc_flags[1]) begin
      exc_sel = EXC_TYPE_ADES;
    end else if (mem_exc_flags[0]) begin
      exc_sel = EXC_TYPE_ERET;
    end
  end

  // IDLE captures the winning exception; FLUSH lasts one cycle and blocks any back-to-back exception
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      exception_type  <= EXC_TYPE_NONE;
      flush_o         <= 1'b0;
      delayslot_flag  <= 1'b0;
      current_pc_addr <= 32'h0;
      badvaddr_o      <= 32'h0;
      exc_pc_o        <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exc_sel != EXC_TYPE_NONE) begin
            state           <= ST_FLUSH;
            exception_type  <= exc_sel;
            flush_o         <= 1'b1;
            delayslot_flag  <= mem_delayslot;
            current_pc_addr <= mem_pc;
            badvaddr_o      <= is_fetch_fault ? mem_pc : mem_badvaddr;
            exc_pc_o        <= (exc_sel == EXC_TYPE_ERET) ? epc_byp : EXC_VECTOR;
          end
        end
        ST_FLUSH: begin
          state          <= ST_IDLE;
          exception_type <= EXC_TYPE_NONE;
          flush_o        <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          exception_type <= EXC_TYPE_NONE;
          flush_o        <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXCEPTION_CTRL_TIMER_INT_EN
  logic [31:0] compare_shadow;
  logic        timer_pending;
  logic        compare_wr;
  logic        timer_hit;

  assign compare_wr = wb_cp0_we && (wb_cp0_addr == CP0_REG_COMPARE);
  // Plain 32-bit equality; a zero compare means the timer is disarmed
  assign timer_hit  = (cp0_count_i == compare_shadow) && (compare_shadow != 32'h0);

  // Shadow compare tracks CP0 writes; a compare write clears the pending timer and beats a same-cycle hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      compare_shadow <= 32'h0;
      timer_pending  <= 1'b0;
    end else if (compare_wr) begin
      compare_shadow <= wb_cp0_data;
      timer_pending  <= 1'b0;
    end else if (timer_hit) begin
      timer_pending  <= 1'b1;
    end
  end

  assign interrupt_o = {interrupt_i[5] | timer_pending, interrupt_i[4:0]};
  assign unused_bits = ^{status_byp[31:16], status_byp[7:2], cause_byp[31:16], cause_byp[7:0]};
`else
  assign interrupt_o = interrupt_i;
  assign unused_bits = ^{status_byp[31:16], status_byp[7:2], cause_byp[31:16], cause_byp[7:0],
                         cp0_count_i};
`endif

endmodule
